lc4_branch_resolve: RTL and testbench
=====================================

LC4_BRANCH_RESOLVE -- requirements
Module: lc4_branch_resolve

Interface
REQ-001 The block SHALL have one clock: clk, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL have one reset: rst, input, 1, asynchronous, active-low (rst=0 resets).
REQ-003 The block SHALL have gwe, input, 1, global write enable; no state changes when gwe=0.
REQ-004 The block SHALL have in_valid, input, 1, an instruction is presented this cycle.
REQ-005 The block SHALL have is_branch, input, 1, the presented instruction is BR.
REQ-006 The block SHALL have br_cond, input, 3, branch condition mask {n,z,p} (insn[11:9]).
REQ-007 The block SHALL have imm9, input, 9, signed branch offset (insn[8:0]).
REQ-008 The block SHALL have pc, input, 16, PC of the presented instruction.
REQ-009 The block SHALL have nzp_we, input, 1, the presented instruction writes NZP.
REQ-010 The block SHALL have wdata, input, 16, the register-file write value that sets NZP.
REQ-011 The block SHALL have out_valid, output, 1, registered result is valid.
REQ-012 The block SHALL have taken, output, 1, registered branch-taken flag.
REQ-013 The block SHALL have next_pc, output, 16, registered next PC.
REQ-014 The block SHALL have nzp, output, 3, current NZP register {n,z,p}.
REQ-015 The block SHALL have br_cnt and taken_cnt, outputs, 16 each, branch and taken-branch statistics.

Function
REQ-016 The NZP register SHALL load on a rising edge with gwe=1, in_valid=1, nzp_we=1: 3'b100 if wdata[15]=1, 3'b010 if wdata=0, 3'b001 otherwise.
REQ-017 Branch evaluation SHALL use the NZP value held before the edge; a same-cycle nzp_we affects only later instructions.
REQ-018 The taken condition SHALL be is_branch & |(br_cond & nzp); br_cond=000 is never taken, br_cond=111 is always taken.
REQ-019 The target SHALL be pc + 1 + sign_extend(imm9), modulo 2^16; the fall-through SHALL be pc + 1, modulo 2^16 (0xFFFF+1 = 0x0000).
REQ-020 On an edge with gwe=1, in_valid=1: out_valid<=1, taken<=condition, next_pc<=(taken ? target : fall-through); a non-branch yields taken=0 and next_pc=pc+1.
REQ-021 On an edge with gwe=1, in_valid=0: out_valid<=0, taken<=0, next_pc holds, nzp holds.
REQ-022 On an edge with gwe=0: every register holds, regardless of other inputs.
REQ-023 Result latency SHALL be exactly one gwe-qualified edge; back-to-back valid instructions SHALL produce one result per edge.
REQ-024 br_cnt SHALL increment on each gwe&in_valid&is_branch edge; taken_cnt on each such edge with condition true; both SHALL saturate at 0xFFFF.
REQ-025 Inputs with in_valid=0 SHALL have no effect on any register.

Reset
REQ-026 rst=0 SHALL immediately force nzp=3'b010, out_valid=0, taken=0, next_pc=0x0000, br_cnt=0, taken_cnt=0, independent of clk.
REQ-027 Reset asserted mid-stream SHALL discard the in-flight result; the first update SHALL occur on the first gwe-qualified edge with rst=1.

Verification
REQ-028 Reset then BRz (br_cond=010, imm9=0x005, pc=0x0010) -> out_valid=1, taken=1, next_pc=0x0016, br_cnt=1, taken_cnt=1.
REQ-029 Write wdata=0x8000 (nzp_we=1), then BRp imm9=0x1FF, pc=0x0020 -> nzp=100, taken=0, next_pc=0x0021; BRn same -> taken=1, next_pc=0x0020.
REQ-030 Same-cycle is_branch=1, br_cond=001, nzp_we=1, wdata=0x0003 with prior nzp=010 -> taken=0; next cycle nzp=001.
REQ-031 gwe=0 with in_valid=1, nzp_we=1 for 3 edges -> nzp, out_valid, next_pc, counters unchanged; in_valid=0 with gwe=1 -> out_valid=0.
REQ-032 Preload counters to 0xFFFF via 65535 taken BRnzp, then one more -> both counters remain 0xFFFF; pc=0xFFFF non-branch -> next_pc=0x0000.
REQ-033 Assert rst=0 between clock edges during a stream -> all outputs reach reset values before the next edge; stream resumes correctly after release.

Source files
------------

// File: rtl/lc4_branch_resolve_if.sv
// Instruction-in / branch-result-out bus for the LC4 branch resolver.
interface lc4_branch_resolve_if;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned IMM_W  = 9;
    localparam int unsigned COND_W = 3;

    logic                in_valid;
    logic                is_branch;
    logic [COND_W-1:0]   br_cond;
    logic [IMM_W-1:0]    imm9;
    logic [WORD_W-1:0]   pc;
    logic                nzp_we;
    logic [WORD_W-1:0]   wdata;

    logic                out_valid;
    logic                taken;
    logic [WORD_W-1:0]   next_pc;

    modport master (
        output in_valid, is_branch, br_cond, imm9, pc, nzp_we, wdata,
        input  out_valid, taken, next_pc
    );

    modport slave (
        input  in_valid, is_branch, br_cond, imm9, pc, nzp_we, wdata,
        output out_valid, taken, next_pc
    );
endinterface

// File: rtl/lc4_branch_resolve.sv
// LC4 branch resolution: NZP register, taken decision, next-PC and branch statistics.
// All state advances only on gwe-qualified rising edges; rst is async active-low.
module lc4_branch_resolve (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gwe,
    lc4_branch_resolve_if.slave   bus,
    output logic [2:0]            nzp,
    output logic [15:0]           br_cnt,
    output logic [15:0]           taken_cnt
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned IMM_W  = 9;
    localparam int unsigned NZP_W  = 3;

    logic [NZP_W-1:0]  nzp_q;
    logic              out_valid_q;
    logic              taken_q;
    logic [WORD_W-1:0] next_pc_q;
    logic [WORD_W-1:0] br_cnt_q;
    logic [WORD_W-1:0] taken_cnt_q;

    logic              upd_c;
    logic              cond_c;
    logic [NZP_W-1:0]  nzp_new_c;
    logic [WORD_W-1:0] fall_c;
    logic [WORD_W-1:0] target_c;
    logic [WORD_W-1:0] imm_sext_c;

    // Decision logic: evaluated against the NZP value held before the edge.
    always_comb begin
        upd_c      = gwe & bus.in_valid;
        cond_c     = bus.is_branch & (|(bus.br_cond & nzp_q));
        imm_sext_c = {{(WORD_W-IMM_W){bus.imm9[IMM_W-1]}}, bus.imm9};
        fall_c     = bus.pc + WORD_W'(1);
        target_c   = fall_c + imm_sext_c;
        if (bus.wdata[WORD_W-1]) begin
            nzp_new_c = 3'b100;
        end else if (bus.wdata == '0) begin
            nzp_new_c = 3'b010;
        end else begin
            nzp_new_c = 3'b001;
        end
    end

    // Result pipeline and NZP register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nzp_q       <= 3'b010;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            next_pc_q   <= '0;
        end else if (gwe) begin
            if (bus.in_valid) begin
                out_valid_q <= 1'b1;
                taken_q     <= cond_c;
                next_pc_q   <= cond_c ? target_c : fall_c;
                if (bus.nzp_we) begin
                    nzp_q <= nzp_new_c;
                end
            end else begin
                out_valid_q <= 1'b0;
                taken_q     <= 1'b0;
            end
        end
    end

    // Saturating branch statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else if (upd_c && bus.is_branch) begin
            if (br_cnt_q != '1) begin
                br_cnt_q <= br_cnt_q + WORD_W'(1);
            end
            if (cond_c && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + WORD_W'(1);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.taken     = taken_q;
    assign bus.next_pc   = next_pc_q;
    assign nzp           = nzp_q;
    assign br_cnt        = br_cnt_q;
    assign taken_cnt     = taken_cnt_q;
endmodule

// File: tb/tb_lc4_branch_resolve.sv
// Directed, table-driven bench for lc4_branch_resolve plus saturation and async-reset sequences.
module tb_lc4_branch_resolve;
    logic        clk;
    logic        rst;
    logic        gwe;
    logic [2:0]  nzp;
    logic [15:0] br_cnt;
    logic [15:0] taken_cnt;

    int checks;
    int errors;

    lc4_branch_resolve_if bus ();

    lc4_branch_resolve dut (
        .clk       (clk),
        .rst       (rst),
        .gwe       (gwe),
        .bus       (bus.slave),
        .nzp       (nzp),
        .br_cnt    (br_cnt),
        .taken_cnt (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gwe;
        logic        in_valid;
        logic        is_branch;
        logic [2:0]  br_cond;
        logic [8:0]  imm9;
        logic [15:0] pc;
        logic        nzp_we;
        logic [15:0] wdata;
        logic        ov;
        logic        tk;
        logic [15:0] npc;
        logic [2:0]  enzp;
        logic [15:0] bc;
        logic [15:0] tc;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic g, input logic v, input logic b, input logic [2:0] c,
                         input logic [8:0] imm, input logic [15:0] p, input logic we,
                         input logic [15:0] wd);
        gwe           = g;
        bus.in_valid  = v;
        bus.is_branch = b;
        bus.br_cond   = c;
        bus.imm9      = imm;
        bus.pc        = p;
        bus.nzp_we    = we;
        bus.wdata     = wd;
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic tk, input logic [15:0] npc,
                           input logic [2:0] enzp, input logic [15:0] bc, input logic [15:0] tc);
        chk({tag, ".out_valid"}, 16'(bus.out_valid), 16'(ov));
        chk({tag, ".taken"},     16'(bus.taken),     16'(tk));
        chk({tag, ".next_pc"},   bus.next_pc,        npc);
        chk({tag, ".nzp"},       16'(nzp),           16'(enzp));
        chk({tag, ".br_cnt"},    br_cnt,             bc);
        chk({tag, ".taken_cnt"}, taken_cnt,          tc);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 1'b0, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 16'h0000, 3'b010, 16'h0000, 16'h0000);
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            gwe v  br cond    imm9    pc        we wdata     ov tk npc       nzp     bc        tc
        vecs[0]  = '{1'b1,1'b1,1'b1,3'b010,9'h005,16'h0010,1'b0,16'h0000, 1'b1,1'b1,16'h0016,3'b010,16'd1,16'd1};
        vecs[1]  = '{1'b1,1'b1,1'b0,3'b000,9'h000,16'h0016,1'b1,16'h8000, 1'b1,1'b0,16'h0017,3'b100,16'd1,16'd1};
        vecs[2]  = '{1'b1,1'b1,1'b1,3'b001,9'h1FF,16'h0020,1'b0,16'h0000, 1'b1,1'b0,16'h0021,3'b100,16'd2,16'd1};
        vecs[3]  = '{1'b1,1'b1,1'b1,3'b100,9'h1FF,16'h0020,1'b0,16'h0000, 1'b1,1'b1,16'h0020,3'b100,16'd3,16'd2};
        vecs[4]  = '{1'b1,1'b1,1'b0,3'b000,9'h000,16'h0030,1'b1,16'h0000, 1'b1,1'b0,16'h0031,3'b010,16'd3,16'd2};
        vecs[5]  = '{1'b1,1'b1,1'b1,3'b001,9'h010,16'h0040,1'b1,16'h0003, 1'b1,1'b0,16'h0041,3'b001,16'd4,16'd2};
        vecs[6]  = '{1'b1,1'b1,1'b1,3'b001,9'h010,16'h0040,1'b0,16'h0000, 1'b1,1'b1,16'h0051,3'b001,16'd5,16'd3};
        vecs[7]  = '{1'b0,1'b1,1'b1,3'b111,9'h000,16'h0100,1'b1,16'h8000, 1'b1,1'b1,16'h0051,3'b001,16'd5,16'd3};
        vecs[8]  = '{1'b0,1'b1,1'b1,3'b111,9'h000,16'h0100,1'b1,16'h8000, 1'b1,1'b1,16'h0051,3'b001,16'd5,16'd3};
        vecs[9]  = '{1'b0,1'b1,1'b1,3'b111,9'h000,16'h0100,1'b1,16'h8000, 1'b1,1'b1,16'h0051,3'b001,16'd5,16'd3};
        vecs[10] = '{1'b1,1'b0,1'b1,3'b111,9'h000,16'h0100,1'b1,16'h8000, 1'b0,1'b0,16'h0051,3'b001,16'd5,16'd3};
        vecs[11] = '{1'b1,1'b1,1'b1,3'b111,9'h1F0,16'h0005,1'b0,16'h0000, 1'b1,1'b1,16'hFFF6,3'b001,16'd6,16'd4};
        vecs[12] = '{1'b1,1'b1,1'b1,3'b000,9'h005,16'h0100,1'b0,16'h0000, 1'b1,1'b0,16'h0101,3'b001,16'd7,16'd4};
        vecs[13] = '{1'b1,1'b1,1'b0,3'b111,9'h000,16'hFFFF,1'b1,16'hFFFF, 1'b1,1'b0,16'h0000,3'b100,16'd7,16'd4};
        vecs[14] = '{1'b1,1'b1,1'b1,3'b111,9'h0FF,16'h0200,1'b0,16'h0000, 1'b1,1'b1,16'h0300,3'b100,16'd8,16'd5};

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].gwe, vecs[i].in_valid, vecs[i].is_branch, vecs[i].br_cond,
                  vecs[i].imm9, vecs[i].pc, vecs[i].nzp_we, vecs[i].wdata);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].tk, vecs[i].npc,
                    vecs[i].enzp, vecs[i].bc, vecs[i].tc);
        end

        // Counter saturation: 65535 taken BRnzp, then more must stick at 0xFFFF.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 3'b111, 9'h000, 16'h1000, 1'b0, 16'h0000);
        for (int i = 0; i < 65535; i++) @(posedge clk);
        #1;
        chk_all("sat_preload", 1'b1, 1'b1, 16'h1001, 3'b010, 16'hFFFF, 16'hFFFF);
        @(posedge clk);
        #1;
        chk_all("sat_taken", 1'b1, 1'b1, 16'h1001, 3'b010, 16'hFFFF, 16'hFFFF);
        drive(1'b1, 1'b1, 1'b1, 3'b100, 9'h000, 16'h1000, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        chk_all("sat_not_taken", 1'b1, 1'b0, 16'h1001, 3'b010, 16'hFFFF, 16'hFFFF);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 9'h000, 16'hFFFF, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        chk_all("pc_wrap", 1'b1, 1'b0, 16'h0000, 3'b010, 16'hFFFF, 16'hFFFF);

        // Async reset between edges during a stream.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 3'b010, 9'h003, 16'h0050, 1'b1, 16'h8000);
        @(posedge clk);
        #1;
        chk_all("pre_async", 1'b1, 1'b1, 16'h0054, 3'b100, 16'd1, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 16'h0000, 3'b010, 16'h0000, 16'h0000);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'b010, 9'h005, 16'h0010, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        chk_all("resume", 1'b1, 1'b1, 16'h0016, 3'b010, 16'd1, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
